// File: rtl/instr_cache.sv
// instr_cache: direct-mapped, read-only instruction cache with one-word lines.
//   Hits are served combinationally in IDLE. On a miss the cache fetches one word
//   from RAM in FETCH, fills the line, and returns to IDLE. The held request then
//   looks up again and hits there.
// Ports:
//   CLK, nRST                 clock (rising edge), asynchronous active-low reset
//   imemREN, imemaddr         datapath fetch request and byte address ([1:0] ignored)
//   flush                     single-cycle pulse that invalidates every line
//   ihit, imemload            hit strobe and instruction word (combinational)
//   iREN, iaddr               RAM read request and word address (registered)
//   iwait, iload              RAM busy flag and read data
//   hit_count, miss_count     saturating performance counters
module instr_cache #(
    parameter int SETS  = 16,
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             imemREN,
    input  logic [31:0]      imemaddr,
    input  logic             flush,
    output logic             ihit,
    output logic [31:0]      imemload,
    output logic             iREN,
    output logic [31:0]      iaddr,
    input  logic             iwait,
    input  logic [31:0]      iload,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count
);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 30 - IDX_W;

    typedef enum logic {IDLE, FETCH} state_t;

    state_t             state;
    logic               flush_pend;   // flush seen during this FETCH: fill must not validate
    logic [SETS-1:0]    valid;
    logic [TAG_W-1:0]   tags [SETS];
    logic [31:0]        data [SETS];

    logic [IDX_W-1:0]   idx, fill_idx;
    logic [TAG_W-1:0]   tag, fill_tag;
    logic               lookup_hit, miss, fill_done;
    logic               unused_bits;

    assign idx         = imemaddr[IDX_W+1:2];
    assign tag         = imemaddr[31:IDX_W+2];
    // The in-flight line is identified by the registered RAM address, so later
    // changes on imemaddr cannot redirect the fill.
    assign fill_idx    = iaddr[IDX_W+1:2];
    assign fill_tag    = iaddr[31:IDX_W+2];
    assign unused_bits = ^imemaddr[1:0];

    always_comb begin
        lookup_hit = valid[idx] && (tags[idx] == tag);
        // A flush cycle performs no lookup at all: no hit and no miss is taken.
        ihit       = (state == IDLE) && imemREN && !flush && lookup_hit;
        miss       = (state == IDLE) && imemREN && !flush && !lookup_hit;
        imemload   = ihit ? data[idx] : '0;
        fill_done  = (state == FETCH) && !iwait;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state      <= IDLE;
            iREN       <= 1'b0;
            iaddr      <= '0;
            flush_pend <= 1'b0;
            valid      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (miss) begin
                        state      <= FETCH;
                        iREN       <= 1'b1;
                        iaddr      <= {imemaddr[31:2], 2'b00};
                        flush_pend <= 1'b0;
                    end
                end
                FETCH: begin
                    if (!iwait) begin
                        state      <= IDLE;
                        iREN       <= 1'b0;
                        flush_pend <= 1'b0;
                    end else if (flush) begin
                        flush_pend <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase

            if (flush)
                valid <= '0;
            else if (fill_done && !flush_pend)
                valid[fill_idx] <= 1'b1;
        end
    end

    // Line payload carries no reset; valid bits gate every use.
    always_ff @(posedge CLK) begin
        if (fill_done) begin
            data[fill_idx] <= iload;
            tags[fill_idx] <= fill_tag;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (ihit && hit_count != '1)
                hit_count <= hit_count + 1'b1;
            if (miss && miss_count != '1)
                miss_count <= miss_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_instr_cache.sv
// tb_instr_cache: scoreboard bench for instr_cache. The driver pushes expected
// instruction words, a monitor pops them on every ihit, and a RAM responder
// process answers fetches with random (or fixed) latency. A line-level model
// (valid flag + stored word address per set) predicts hits, misses and counters.
module tb_instr_cache;
    localparam int SETS  = 16;
    localparam int CNT_W = 8;
    localparam int IDX_W = 4;

    logic             CLK = 1'b0;
    logic             nRST;
    logic             imemREN;
    logic [31:0]      imemaddr;
    logic             flush;
    logic             ihit;
    logic [31:0]      imemload;
    logic             iREN;
    logic [31:0]      iaddr;
    logic             iwait;
    logic [31:0]      iload;
    logic [CNT_W-1:0] hit_count;
    logic [CNT_W-1:0] miss_count;

    instr_cache #(.SETS(SETS), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .nRST(nRST), .imemREN(imemREN), .imemaddr(imemaddr), .flush(flush),
        .ihit(ihit), .imemload(imemload), .iREN(iREN), .iaddr(iaddr),
        .iwait(iwait), .iload(iload), .hit_count(hit_count), .miss_count(miss_count)
    );

    initial forever #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // reference model
    bit          mv [SETS];
    logic [29:0] mw [SETS];
    int          m_hits = 0;
    int          m_misses = 0;
    logic [31:0] exp_q [$];

    // RAM responder bookkeeping
    int          fixed_lat = -1;
    int          lat = 0;
    int          run = 0;
    int          last_run = 0;
    logic [31:0] run_addr = '0;
    logic [31:0] fetch_log [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] memf(input logic [31:0] a);
        if (a == 32'h40) return 32'h2001_0005;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    function automatic logic [31:0] sat(input int v);
        int mx;
        mx = (1 << CNT_W) - 1;
        return (v > mx) ? 32'(mx) : 32'(v);
    endfunction

    task automatic model_clear();
        for (int s = 0; s < SETS; s++) mv[s] = 1'b0;
    endtask

    // RAM: latency counted in FETCH cycles with iwait high before the data cycle.
    initial begin
        iwait = 1'b1;
        iload = '0;
        forever begin
            @(negedge CLK);
            if (!iREN) begin
                if (run > 0) last_run = run;
                run   = 0;
                iwait = 1'b1;
                lat   = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
            end else begin
                if (run == 0) begin
                    fetch_log.push_back(iaddr);
                    run_addr = iaddr;
                end else begin
                    chk("iaddr_stable", iaddr, run_addr);
                end
                run++;
                if (lat == 0) begin
                    iwait = 1'b0;
                    iload = memf(iaddr);
                end else begin
                    iwait = 1'b1;
                    lat--;
                end
            end
        end
    end

    // Monitor: every ihit consumes one expected word.
    initial forever begin
        @(negedge CLK);
        if (nRST) begin
            if (ihit) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ihit: imemload %h with nothing expected", imemload);
                end else begin
                    chk("imemload", imemload, exp_q.pop_front());
                end
            end else begin
                chk("imemload_nohit", imemload, 32'h0);
            end
        end
    end

    task automatic check_counts(input string tagn);
        chk({tagn, "_hit_count"},  32'(hit_count),  sat(m_hits));
        chk({tagn, "_miss_count"}, 32'(miss_count), sat(m_misses));
    endtask

    // One fetch held until ihit; fl injects a flush pulse in the first FETCH cycle.
    task automatic req(input logic [31:0] a, input bit fl);
        logic [IDX_W-1:0] i;
        bit               hit;
        bit               fdone;
        int               nmiss;
        int               t;
        i     = a[IDX_W+1:2];
        hit   = mv[i] && (mw[i] == a[31:2]);
        nmiss = hit ? 0 : (fl ? 2 : 1);
        fdone = 1'b0;
        fetch_log.delete();
        exp_q.push_back(memf({a[31:2], 2'b00}));
        @(posedge CLK); #1;
        imemREN  = 1'b1;
        imemaddr = {a[31:2], 2'($urandom_range(0, 3))};
        flush    = 1'b0;
        @(negedge CLK);
        chk("first_cycle_hit", 32'(ihit), 32'(hit));
        if (hit) chk("iREN_on_hit", 32'(iREN), 32'h0);
        if (!hit) begin
            for (t = 0; t < 200; t++) begin
                @(posedge CLK); #1;
                flush = fl && !fdone && iREN;
                if (flush) fdone = 1'b1;
                @(negedge CLK);
                if (ihit) break;
            end
            if (t == 200) begin
                checks++;
                errors++;
                $display("FAIL ihit_timeout: no ihit for %h within 200 cycles", a);
            end
        end
        @(posedge CLK); #1;
        imemREN = 1'b0;
        flush   = 1'b0;
        if (fl && !hit) model_clear();
        mv[i] = 1'b1;
        mw[i] = a[31:2];
        m_hits++;
        m_misses += nmiss;
        check_counts("req");
        if (!hit) begin
            chk("fetch_count", 32'(fetch_log.size()), 32'(nmiss));
            if (fetch_log.size() > 0) chk("fetch_iaddr", fetch_log[0], {a[31:2], 2'b00});
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        logic [31:0] pool [4];
        nRST     = 1'b0;
        imemREN  = 1'b0;
        imemaddr = '0;
        flush    = 1'b0;
        model_clear();
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_ihit", 32'(ihit), 32'h0);
        chk("rst_imemload", imemload, 32'h0);
        chk("rst_iREN", 32'(iREN), 32'h0);
        chk("rst_iaddr", iaddr, 32'h0);
        check_counts("rst");
        @(negedge CLK);
        nRST = 1'b1;

        // cold miss with three busy cycles
        fixed_lat = 3;
        req(32'h40, 1'b0);
        fixed_lat = -1;
        chk("t1_iren_cycles", 32'(last_run), 32'd4);
        // re-read hits
        req(32'h40, 1'b0);
        // conflict in set 0
        req(32'h80, 1'b0);
        req(32'h40, 1'b0);
        // flush during fetch: the fill is not kept, held request refetches
        req(32'h100, 1'b1);
        req(32'h100, 1'b0);
        req(32'h80, 1'b0);

        // address change mid-FETCH: 0x44 still filled, then 0x48 fetched
        fetch_log.delete();
        exp_q.push_back(memf(32'h48));
        @(posedge CLK); #1;
        imemREN  = 1'b1;
        imemaddr = 32'h44;
        @(negedge CLK);
        chk("t5_first_cycle_hit", 32'(ihit), 32'h0);
        @(posedge CLK); #1;
        imemaddr = 32'h48;
        for (t = 0; t < 200; t++) begin
            @(negedge CLK);
            if (ihit) break;
            @(posedge CLK);
        end
        if (t == 200) begin
            checks++;
            errors++;
            $display("FAIL t5_timeout: no ihit for 0x48");
        end
        @(posedge CLK); #1;
        imemREN = 1'b0;
        chk("t5_fetches", 32'(fetch_log.size()), 32'd2);
        if (fetch_log.size() == 2) begin
            chk("t5_fetch0", fetch_log[0], 32'h44);
            chk("t5_fetch1", fetch_log[1], 32'h48);
        end
        mv[1] = 1'b1; mw[1] = 30'h11;
        mv[2] = 1'b1; mw[2] = 30'h12;
        m_misses += 2;
        m_hits++;
        check_counts("t5");
        req(32'h44, 1'b0);

        // random traffic with occasional idle flushes and flush-in-fetch
        repeat (500) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r == 0) begin
                @(posedge CLK); #1;
                flush    = 1'b1;
                imemaddr = $urandom;
                @(negedge CLK);
                chk("idle_flush_ihit", 32'(ihit), 32'h0);
                @(posedge CLK); #1;
                flush = 1'b0;
                model_clear();
            end else begin
                req(32'($urandom_range(0, 23)) << 2, r == 1);
            end
        end
        // drive hit counter into saturation
        repeat (260) req(32'h40, 1'b0);

        // reset in the middle of a fetch
        fixed_lat = 10;
        @(posedge CLK); #1;
        imemREN  = 1'b1;
        imemaddr = 32'h3000;
        @(posedge CLK);
        @(posedge CLK);
        #2;
        nRST = 1'b0;
        #1;
        chk("t6_iREN_async", 32'(iREN), 32'h0);
        chk("t6_ihit", 32'(ihit), 32'h0);
        imemREN = 1'b0;
        exp_q.delete();
        model_clear();
        m_hits   = 0;
        m_misses = 0;
        check_counts("t6_rst");
        fixed_lat = -1;
        @(negedge CLK);
        #2;
        nRST = 1'b1;
        pool[0] = 32'h40; pool[1] = 32'h44; pool[2] = 32'h48; pool[3] = 32'h100;
        for (int k = 0; k < 4; k++) req(pool[k], 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
